// File: rtl/double_fp_pkg.sv
// Shared IEEE-754 double field constants and the converter state encoding.
// The divider stage imports the same bias and field-width constants.
package double_fp_pkg;

  localparam int          MANT_W       = 52;
  localparam logic [11:0] EXP_BIAS     = 12'd1023;
  localparam logic [10:0] EXP_ALL_ONES = 11'd2047;

  localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  localparam logic [2:0] ST_GET_A   = 3'd0;
  localparam logic [2:0] ST_UNPACK  = 3'd1;
  localparam logic [2:0] ST_SPECIAL = 3'd2;
  localparam logic [2:0] ST_ALIGN   = 3'd3;
  localparam logic [2:0] ST_PACK    = 3'd4;
  localparam logic [2:0] ST_PUT_Z   = 3'd5;

  typedef enum logic [2:0] {
    GET_A   = ST_GET_A,
    UNPACK  = ST_UNPACK,
    SPECIAL = ST_SPECIAL,
    ALIGN   = ST_ALIGN,
    PACK    = ST_PACK,
    PUT_Z   = ST_PUT_Z
  } state_t;

endpackage

// File: rtl/double_to_long_converter.sv
// Double -> signed 64-bit integer, truncating toward zero and saturating.
// The mantissa is aligned one bit per cycle; stb/ack handshake on both sides.
module double_to_long_converter
  import double_fp_pkg::*;
#(
  parameter logic [63:0] NAN_RESULT = 64'h8000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             state_r;
  logic [63:0]        a_r;
  logic [63:0]        mant_r;
  logic               sign_r;
  logic signed [11:0] exp_r;
  logic [5:0]         cnt_r;

  logic               exp_max_s;
  logic               frac_nz_s;
  logic [5:0]         shift_n_s;

  // Field decode and alignment distance |E - 52| (only used when 0 <= E <= 62).
  always_comb begin
    exp_max_s = (a_r[62:52] == EXP_ALL_ONES);
    frac_nz_s = |a_r[MANT_W-1:0];
    if (exp_r[5:0] > 6'(MANT_W)) begin
      shift_n_s = exp_r[5:0] - 6'(MANT_W);
    end else begin
      shift_n_s = 6'(MANT_W) - exp_r[5:0];
    end
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= GET_A;
      a_r          <= 64'd0;
      mant_r       <= 64'd0;
      sign_r       <= 1'b0;
      exp_r        <= 12'sd0;
      cnt_r        <= 6'd0;
      input_a_ack  <= 1'b0;
      output_z     <= 64'd0;
      output_z_stb <= 1'b0;
    end else begin
      case (state_r)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_r         <= input_a;
            input_a_ack <= 1'b0;
            state_r     <= UNPACK;
          end else begin
            input_a_ack <= 1'b1;
          end
        end

        UNPACK: begin
          sign_r  <= a_r[63];
          exp_r   <= $signed({1'b0, a_r[62:52]} - EXP_BIAS);
          mant_r  <= {11'd0, 1'b1, a_r[MANT_W-1:0]};
          state_r <= SPECIAL;
        end

        SPECIAL: begin
          if (exp_max_s && frac_nz_s) begin
            output_z     <= NAN_RESULT;
            output_z_stb <= 1'b1;
            state_r      <= PUT_Z;
          end else if (exp_max_s || (exp_r >= 12'sd63)) begin
            // -2^63 lands here and its saturated value is also the exact one.
            output_z     <= sign_r ? INT64_MIN : INT64_MAX;
            output_z_stb <= 1'b1;
            state_r      <= PUT_Z;
          end else if (exp_r[11]) begin
            output_z     <= 64'd0;
            output_z_stb <= 1'b1;
            state_r      <= PUT_Z;
          end else if (shift_n_s == 6'd0) begin
            state_r <= PACK;
          end else begin
            cnt_r   <= shift_n_s;
            state_r <= ALIGN;
          end
        end

        ALIGN: begin
          if (exp_r > 12'sd52) begin
            mant_r <= mant_r << 1;
          end else begin
            mant_r <= mant_r >> 1;
          end
          cnt_r <= cnt_r - 6'd1;
          if (cnt_r == 6'd1) begin
            state_r <= PACK;
          end else begin
            state_r <= ALIGN;
          end
        end

        PACK: begin
          output_z     <= sign_r ? (64'd0 - mant_r) : mant_r;
          output_z_stb <= 1'b1;
          state_r      <= PUT_Z;
        end

        PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state_r      <= GET_A;
          end else begin
            output_z_stb <= 1'b1;
          end
        end

        default: begin
          input_a_ack  <= 1'b0;
          output_z_stb <= 1'b0;
          state_r      <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_long_converter.sv
// Self-checking bench for double_to_long_converter: directed table, backpressure,
// mid-operation reset and randomized values against a real-arithmetic model.
module tb_double_to_long_converter;

  logic        clk;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks;
  int errors;

  double_to_long_converter dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: trunc toward zero of the real value, saturated to int64, NaN -> 0x8000...
  function automatic logic [63:0] ref_trunc(input logic [63:0] bits);
    real    x;
    real    t;
    longint v;
    x = $bitstoreal(bits);
    if (x != x) return 64'h8000_0000_0000_0000;
    if (x >= 9223372036854775808.0) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (x <= -9223372036854775808.0) return 64'h8000_0000_0000_0000;
    t = $floor((x < 0.0) ? -x : x);
    v = longint'(t);
    return (x < 0.0) ? -v : v;
  endfunction

  // Offers one operand, then counts edges from accept until output_z_stb rises.
  task automatic do_convert(input logic [63:0] a, output logic [63:0] z,
                            output int lat, output bit ack_seen, output bit timeout);
    int guard;
    guard    = 0;
    ack_seen = 1'b0;
    timeout  = 1'b0;
    @(negedge clk);
    while (!input_a_ack && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) timeout = 1'b1;
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    lat = 0;
    while (!output_z_stb && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (input_a_ack) ack_seen = 1'b1;
    end
    if (lat >= 200) timeout = 1'b1;
    z = output_z;
  endtask

  // Accepts the pending result with a single-cycle ack.
  task automatic release_output();
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: ack=%b stb=%b z=%h, required 0 0 0", input_a_ack, output_z_stb, output_z);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_ack_rise: ack=%b, required 1", input_a_ack);
    end
  endtask

  task automatic test_directed();
    logic [63:0] vec_a   [13];
    logic [63:0] vec_z   [13];
    int          vec_lat [13];
    logic [63:0] z;
    int          lat;
    bit          ack_seen;
    bit          to;
    vec_a = '{64'h3FF0000000000000, 64'hC004000000000000, 64'h3FE0000000000000,
              64'h4330000000000000, 64'h43D0000000000000, 64'h7FF8000000000000,
              64'h7FF0000000000000, 64'h43E158E460913D00, 64'hC3E0000000000000,
              64'hFFF0000000000000, 64'h8000000000000000, 64'h0000000000000001,
              64'h43DFFFFFFFFFFFFF};
    vec_z = '{64'd1, 64'hFFFFFFFFFFFFFFFE, 64'd0,
              64'd4503599627370496, 64'h4000000000000000, 64'h8000000000000000,
              64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 64'h8000000000000000,
              64'h8000000000000000, 64'd0, 64'd0,
              64'h7FFFFFFFFFFFFC00};
    vec_lat = '{55, 54, 2, 3, 13, 2, 2, 2, 2, 2, 2, 2, 13};
    for (int i = 0; i < 13; i++) begin
      do_convert(vec_a[i], z, lat, ack_seen, to);
      checks++;
      if (to || z !== vec_z[i]) begin
        errors++;
        $display("FAIL directed_value[%0d] a=%h: got %h, required %h (timeout=%0b)", i, vec_a[i], z, vec_z[i], to);
      end
      checks++;
      if (lat != vec_lat[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d] a=%h: got %0d, required %0d", i, vec_a[i], lat, vec_lat[i]);
      end
      checks++;
      if (ack_seen) begin
        errors++;
        $display("FAIL directed_busy_ack[%0d]: input_a_ack high during conversion, required low", i);
      end
      release_output();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] z;
    int          lat;
    bit          ack_seen;
    bit          to;
    do_convert(64'h43D0000000000000, z, lat, ack_seen, to);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (output_z !== 64'h4000000000000000 || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: z=%h stb=%b ack=%b, required 4000000000000000 1 0", c, output_z, output_z_stb, input_a_ack);
      end
    end
    release_output();
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: stb=%b ack=%b, required 0 0", output_z_stb, input_a_ack);
    end
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ack_return: ack=%b, required 1", input_a_ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] z;
    int          lat;
    bit          ack_seen;
    bit          to;
    @(negedge clk);
    input_a     = 64'h3FF0000000000000;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_async: ack=%b stb=%b z=%h, required 0 0 0", input_a_ack, output_z_stb, output_z);
    end
    @(negedge clk);
    rst = 1'b0;
    do_convert(64'h4008000000000000, z, lat, ack_seen, to);
    checks++;
    if (to || z !== 64'd3 || lat != 54) begin
      errors++;
      $display("FAIL reset_mid_recover: z=%h lat=%0d, required 3 at 54 (timeout=%0b)", z, lat, to);
    end
    release_output();
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] z;
    logic [63:0] exp_z;
    int          lat;
    bit          ack_seen;
    bit          to;
    real         ra;
    real         rb;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: a = {$urandom, $urandom};
        1: begin
          a[63]    = $urandom_range(0, 1) == 1;
          a[62:52] = 11'($urandom_range(1020, 1089));
          a[51:0]  = {20'($urandom), $urandom};
        end
        default: begin
          ra = real'($signed($urandom)) * 1024.0;
          rb = real'($urandom_range(1, 5000)) / 7.0;
          if ($urandom_range(0, 1) == 1) rb = -rb;
          a = $realtobits(ra / rb);
        end
      endcase
      exp_z = ref_trunc(a);
      do_convert(a, z, lat, ack_seen, to);
      checks++;
      if (to || z !== exp_z) begin
        errors++;
        $display("FAIL random_value[%0d] a=%h: got %h, required %h (timeout=%0b)", i, a, z, exp_z, to);
      end
      release_output();
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    input_a      = 64'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
